// File: rtl/vit_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : vit_frame_ctrl                                            |
// | Brief    : Frame sequencer for vitDecoder: clear, feed, flush, emit. |
// | Option   : VIT_CTRL_WDOG_EN adds the FLUSH watchdog and oErr.        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module vit_frame_ctrl #(
    parameter int LEN_W     = 12,
    parameter int CLR_CYC   = 2,
    parameter int FLUSH_MAX = 255
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [LEN_W-1:0] iLen,
    input  logic             iPairValid,
    input  logic [1:0]       iPair,
    output logic             oPairReady,
    output logic             oDecRst,
    output logic             oDecEN,
    output logic [1:0]       oDecData,
    input  logic             iDecData,
    input  logic             iDecValid,
    output logic             oBit,
    output logic             oBitValid,
    output logic             oBusy,
    output logic             oDone,
    output logic             oErr
);

    localparam int                 CLR_W      = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam logic [CLR_W-1:0]   c_clr_last = CLR_W'(CLR_CYC - 1);
    localparam logic [CLR_W-1:0]   c_clr_one  = CLR_W'(1);
    localparam logic [LEN_W-1:0]   c_len_one  = LEN_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_FEED  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] len_last;
    logic [LEN_W-1:0] in_cnt;
    logic [LEN_W-1:0] out_cnt;
    logic [CLR_W-1:0] clr_cnt;
    logic             dec_en_r;
    logic [1:0]       dec_data_r;
    logic             bit_r;
    logic             bit_valid_r;
    logic             done_r;
    logic             hs;
    logic             fwd;
    logic             last_bit;
    logic             flush_exit;
    logic             wdog_trip;

    assign len_last   = len_r - c_len_one;
    assign hs         = (state == ST_FEED) && iPairValid;
    // Bits beyond the frame length are traceback flush output and are dropped.
    assign fwd        = ((state == ST_FEED) || (state == ST_FLUSH)) && iDecValid
                        && (out_cnt != len_r);
    assign last_bit   = fwd && (out_cnt == len_last);
    // Exit on the same edge that registers the final bit.
    assign flush_exit = (out_cnt == len_r) || last_bit;

`ifdef VIT_CTRL_WDOG_EN
    localparam int                FL_W         = $clog2(FLUSH_MAX + 1);
    localparam logic [FL_W-1:0]   c_flush_last = FL_W'(FLUSH_MAX - 1);
    localparam logic [FL_W-1:0]   c_flush_one  = FL_W'(1);

    logic [FL_W-1:0] flush_cnt;
    logic            abort_r;
    logic            err_r;

    assign wdog_trip = (state == ST_FLUSH) && !flush_exit && (flush_cnt == c_flush_last);
    assign oErr      = err_r;

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            flush_cnt <= '0;
            abort_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            flush_cnt <= (state == ST_FLUSH) ? flush_cnt + c_flush_one : '0;
            if (wdog_trip) begin
                abort_r <= 1'b1;
            end else if (state == ST_IDLE) begin
                abort_r <= 1'b0;
            end
            err_r <= (state == ST_DONE) && abort_r;
        end
    end
`else
    logic unused_flush_max;
    assign unused_flush_max = (FLUSH_MAX != 0);
    assign wdog_trip        = 1'b0;
    assign oErr             = 1'b0;
`endif

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        oDecRst    = 1'b0;
        oPairReady = 1'b0;
        oBusy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                oDecRst = 1'b1;
                if (iStart) begin
                    state_nxt = (iLen == '0) ? ST_DONE : ST_CLR;
                end
            end
            ST_CLR: begin
                oDecRst = 1'b1;
                if (clr_cnt == c_clr_last) begin
                    state_nxt = ST_FEED;
                end
            end
            ST_FEED: begin
                oPairReady = 1'b1;
                if (hs && (in_cnt == len_last)) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_exit || wdog_trip) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            len_r       <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            clr_cnt     <= '0;
            dec_en_r    <= 1'b0;
            dec_data_r  <= 2'b00;
            bit_r       <= 1'b0;
            bit_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                in_cnt  <= '0;
                out_cnt <= '0;
                if (iStart) begin
                    len_r <= iLen;
                end
            end else begin
                if (hs) begin
                    in_cnt <= in_cnt + c_len_one;
                end
                if (fwd) begin
                    out_cnt <= out_cnt + c_len_one;
                end
            end

            clr_cnt <= (state == ST_CLR) ? clr_cnt + c_clr_one : '0;

            // The decoder only advances on accepted pairs, so upstream gaps are harmless.
            if (state == ST_FEED) begin
                dec_en_r <= hs;
                if (hs) begin
                    dec_data_r <= iPair;
                end
            end else if (state == ST_FLUSH) begin
                dec_en_r   <= (state_nxt == ST_FLUSH);
                dec_data_r <= 2'b00;
            end else begin
                dec_en_r <= 1'b0;
            end

            bit_valid_r <= fwd;
            if (fwd) begin
                bit_r <= iDecData;
            end

            done_r <= (state == ST_DONE);
        end
    end

    assign oDecEN    = dec_en_r;
    assign oDecData  = dec_data_r;
    assign oBit      = bit_r;
    assign oBitValid = bit_valid_r;
    assign oDone     = done_r;

endmodule
`default_nettype wire

// File: tb/tb_vit_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_vit_frame_ctrl                                         |
// | Brief    : Directed bench for vit_frame_ctrl with a delay-line       |
// |            decoder stand-in (bit k = xor of pair k, 5 pushes late).  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_vit_frame_ctrl;

    localparam int LEN_W = 12;
    localparam int MDL_D = 5;

    logic             clk = 1'b0;
    logic             iRst;
    logic             iStart;
    logic [LEN_W-1:0] iLen;
    logic             iPairValid;
    logic [1:0]       iPair;
    logic             oPairReady;
    logic             oDecRst;
    logic             oDecEN;
    logic [1:0]       oDecData;
    logic             iDecData;
    logic             iDecValid;
    logic             oBit;
    logic             oBitValid;
    logic             oBusy;
    logic             oDone;
    logic             oErr;
    logic [9:0]       outvec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vit_frame_ctrl #(
        .LEN_W     (LEN_W),
        .CLR_CYC   (2),
        .FLUSH_MAX (20)
    ) u_dut (
        .iClk       (clk),
        .iRst       (iRst),
        .iStart     (iStart),
        .iLen       (iLen),
        .iPairValid (iPairValid),
        .iPair      (iPair),
        .oPairReady (oPairReady),
        .oDecRst    (oDecRst),
        .oDecEN     (oDecEN),
        .oDecData   (oDecData),
        .iDecData   (iDecData),
        .iDecValid  (iDecValid),
        .oBit       (oBit),
        .oBitValid  (oBitValid),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oErr       (oErr)
    );

    assign outvec = {oPairReady, oDecRst, oDecEN, oDecData, oBit, oBitValid, oBusy, oDone, oErr};

    // Decoder stand-in: each push k>=D emits the xor of the pair pushed D earlier.
    logic [1:0] m_hist [0:1023];
    int         m_n     = 0;
    logic       m_valid = 1'b0;
    logic       m_bit   = 1'b0;
    logic       mute    = 1'b0;

    always @(posedge clk) begin
        if (oDecRst) begin
            m_n     <= 0;
            m_valid <= 1'b0;
        end else if (oDecEN) begin
            m_hist[m_n] <= oDecData;
            m_n         <= m_n + 1;
            m_valid     <= (m_n >= MDL_D);
            if (m_n >= MDL_D) begin
                m_bit <= m_hist[m_n-MDL_D][1] ^ m_hist[m_n-MDL_D][0];
            end
        end else begin
            m_valid <= 1'b0;
        end
    end

    assign iDecValid = m_valid & ~mute;
    assign iDecData  = m_bit;

    logic rec [0:1023];
    int   rec_n    = 0;
    int   done_n   = 0;
    int   err_n    = 0;
    int   en_n     = 0;
    int   rdy_n    = 0;
    int   clr_run  = 0;
    int   clr_seen = 0;
    int   clr_bad  = 0;
    int   en_viol  = 0;
    logic prev_feed = 1'b0;
    logic prev_hs   = 1'b0;

    always @(negedge clk) begin
        if (oBitValid) begin
            rec[rec_n] <= oBit;
            rec_n      <= rec_n + 1;
        end
        if (oDone)      done_n <= done_n + 1;
        if (oErr)       err_n  <= err_n + 1;
        if (oDecEN)     en_n   <= en_n + 1;
        if (oPairReady) rdy_n  <= rdy_n + 1;
        if (oDecRst && oBusy) begin
            clr_run <= clr_run + 1;
        end else if (clr_run != 0) begin
            clr_seen <= clr_seen + 1;
            if (clr_run != 2) clr_bad <= clr_bad + 1;
            clr_run <= 0;
        end
        if (prev_feed && (oDecEN !== prev_hs)) en_viol <= en_viol + 1;
        prev_feed <= oPairReady;
        prev_hs   <= oPairReady && iPairValid;
    end

    logic [1:0] pat [0:69];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_pat(input int k);
        for (int i = 0; i < 70; i++) pat[i] = 2'((i * k + i / 3 + k) % 4);
    endtask

    function automatic logic [127:0] got_bits(input int s, input int n);
        logic [127:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = rec[s+i];
        return v;
    endfunction

    function automatic logic [127:0] exp_bits(input int n);
        logic [127:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = pat[i][1] ^ pat[i][0];
        return v;
    endfunction

    // Must be entered just after a rising edge.
    task automatic send_pair(input logic [1:0] p);
        int t = 0;
        iPair      = p;
        iPairValid = 1'b1;
        @(negedge clk);
        while (!oPairReady && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("pair_ready_timeout", 128'(oPairReady), 128'(1));
        @(posedge clk); #1;
        iPairValid = 1'b0;
    endtask

    task automatic run_frame(input int len, input bit gappy, input int stray_at, output int s);
        s      = rec_n;
        iLen   = LEN_W'(len);
        iStart = 1'b1;
        @(posedge clk); #1;
        iStart = 1'b0;
        iLen   = 12'hABC;
        for (int i = 0; i < len; i++) begin
            if (i == stray_at) begin
                iStart = 1'b1;
                iLen   = 12'd5;
            end
            send_pair(pat[i]);
            iStart = 1'b0;
            if (gappy) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done(output bit seen);
        int t = 0;
        seen = 1'b0;
        while (t < 1000) begin
            @(negedge clk);
            t++;
            if (oDone) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int s;
        int d0;
        int e0;
        int c0;
        int a_en;
        int a_rdy;
        int a_bv;
        int k;
        bit seen;

        iRst = 1'b0; iStart = 1'b0; iLen = '0; iPairValid = 1'b0; iPair = 2'b00;
        repeat (3) @(posedge clk); #1;
        check("reset_outputs", 128'(outvec), 128'(10'h100));
        iRst = 1'b1;
        repeat (2) @(posedge clk); #1;

        // 1: gap-free 70-pair frame
        fill_pat(3);
        d0 = done_n;
        run_frame(70, 1'b0, -1, s);
        wait_done(seen);
        check("t1_done_seen", 128'(seen), 128'(1));
        check("t1_bits", got_bits(s, 70), exp_bits(70));
        check("t1_count_at_done", 128'(rec_n - s), 128'(70));
        repeat (10) @(posedge clk); #1;
        check("t1_no_bits_after_done", 128'(rec_n - s), 128'(70));
        check("t1_done_once", 128'(done_n - d0), 128'(1));

        // 2: same frame, valid toggling
        e0 = en_viol;
        run_frame(70, 1'b1, -1, s);
        wait_done(seen);
        check("t2_done_seen", 128'(seen), 128'(1));
        check("t2_bits", got_bits(s, 70), exp_bits(70));
        check("t2_count", 128'(rec_n - s), 128'(70));
        check("t2_en_follows_accept", 128'(en_viol - e0), 128'(0));

        // 3: zero-length frame
        repeat (3) @(posedge clk); #1;
        a_en = en_n; a_rdy = rdy_n; a_bv = rec_n; d0 = done_n;
        iLen = '0; iStart = 1'b1;
        @(posedge clk); #1;
        iStart = 1'b0;
        check("t3_in_done_state", 128'({oBusy, oDone}), 128'(2'b10));
        @(posedge clk); #1;
        check("t3_done_pulse", 128'({oBusy, oDone}), 128'(2'b01));
        repeat (5) @(posedge clk); #1;
        check("t3_no_dec_en", 128'(en_n - a_en), 128'(0));
        check("t3_no_ready", 128'(rdy_n - a_rdy), 128'(0));
        check("t3_no_bits", 128'(rec_n - a_bv), 128'(0));
        check("t3_done_once", 128'(done_n - d0), 128'(1));

        // 4: stray start during FEED, then back-to-back frames
        c0 = clr_seen; d0 = done_n;
        fill_pat(5);
        run_frame(70, 1'b0, 10, s);
        wait_done(seen);
        check("t4a_done_seen", 128'(seen), 128'(1));
        check("t4a_bits", got_bits(s, 70), exp_bits(70));
        check("t4a_count", 128'(rec_n - s), 128'(70));
        fill_pat(7);
        run_frame(70, 1'b0, -1, s);
        wait_done(seen);
        check("t4b_done_seen", 128'(seen), 128'(1));
        check("t4b_bits", got_bits(s, 70), exp_bits(70));
        repeat (10) @(posedge clk); #1;
        check("t4b_count", 128'(rec_n - s), 128'(70));
        check("t4_clr_runs", 128'(clr_seen - c0), 128'(2));
        check("t4_clr_len_bad", 128'(clr_bad), 128'(0));
        check("t4_done_pulses", 128'(done_n - d0), 128'(2));

        // 5: reset after 30 pairs, then a fresh frame
        fill_pat(9);
        d0 = done_n;
        iLen = 12'd70; iStart = 1'b1;
        @(posedge clk); #1;
        iStart = 1'b0;
        for (int i = 0; i < 30; i++) send_pair(pat[i]);
        iRst = 1'b0;
        @(posedge clk); #1;
        iRst = 1'b1;
        check("t5_reset_outputs", 128'(outvec), 128'(10'h100));
        s = rec_n;
        repeat (20) @(posedge clk); #1;
        check("t5_quiet_bits", 128'(rec_n - s), 128'(0));
        check("t5_no_done", 128'(done_n - d0), 128'(0));
        fill_pat(11);
        run_frame(70, 1'b0, -1, s);
        wait_done(seen);
        check("t5_done_seen", 128'(seen), 128'(1));
        check("t5_bits", got_bits(s, 70), exp_bits(70));
        check("t5_count", 128'(rec_n - s), 128'(70));

`ifdef VIT_CTRL_WDOG_EN
        // 6: decoder silent, watchdog aborts
        repeat (3) @(posedge clk); #1;
        mute = 1'b1;
        e0 = err_n; d0 = done_n;
        run_frame(10, 1'b0, -1, s);
        k = 0;
        while (!oDone && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("t6_abort_latency", 128'(k), 128'(21));
        check("t6_err_with_done", 128'({oErr, oDone}), 128'(2'b11));
        repeat (5) @(posedge clk); #1;
        mute = 1'b0;
        check("t6_err_once", 128'(err_n - e0), 128'(1));
        check("t6_done_once", 128'(done_n - d0), 128'(1));
        check("t6_no_bits", 128'(rec_n - s), 128'(0));
`else
        k = 0;
        check("err_never_high", 128'(err_n), 128'(k));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
